hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS core; it is the stall-and-flush side of the bypass network. Where the forwarding unit resolves dependencies by muxing results, this block detects the dependencies forwarding cannot cover (load-use, and branch or `jr` operands resolved in ID) and freezes or bubbles the pipeline. It also flushes IF/ID on taken control transfers, honours a global memory-busy freeze, and keeps saturating stall and flush performance counters.

## Interface
Parameters:
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous reset, active-high.
- `ID_Rs`, `ID_Rt` in 5: source registers of the instruction in ID.
- `ID_UseRt` in 1: the ID instruction reads Rt as an ALU operand.
- `ID_Branch` in 1: conditional branch in ID; compares Rs and Rt in ID.
- `ID_BranchTaken` in 1: branch outcome computed in ID.
- `ID_PCSrc` in 2: next-PC source. 00 = sequential/branch, 01 = `j`/`jal`, 10 = `jr`/`jalr` (uses Rs in ID), 11 = reserved, treated as 00.
- `EX_MemRead`, `EX_RegWrite` in 1, `EX_WriteReg` in 5: destination info for the EX stage.
- `MEM_MemRead` in 1, `MEM_WriteReg` in 5: destination info for the MEM stage.
- `Mem_Busy` in 1: data or instruction memory is not ready; freezes the whole pipeline.
- `PC_Write`, `IFID_Write`, `EXMEM_Write` out 1: stage register write enables.
- `IFID_Flush`, `IDEX_Flush` out 1: bubble insertion.
- `Stall_Count`, `Flush_Count` out `CNT_W`: performance counters.

## Operation
- Register $0 never causes a hazard. Every match below also requires the producer's WriteReg to be non-zero.
- Branch operands:
  - `brA` = `ID_Branch` OR (`ID_PCSrc` == 10), matched against `ID_Rs`.
  - `brB` = `ID_Branch`, matched against `ID_Rt`.
- ALU operands: Rs is always read; Rt is read only when `ID_UseRt`.
- Hazard classes:
  - **L2**: `EX_MemRead` and EX dest matches a branch operand. Requires 2 stall cycles.
  - **L1**: `EX_MemRead` and EX dest matches an ALU operand, and L2 does not apply. Requires 1 stall cycle.
  - **A1**: `EX_RegWrite` and not `EX_MemRead`, and EX dest matches a branch operand. Requires 1 stall cycle.
  - **M1**: `MEM_MemRead` and MEM dest matches a branch operand. Requires 1 stall cycle.
- Stall cycle: `PC_Write`=0, `IFID_Write`=0, `IDEX_Flush`=1, `IFID_Flush`=0, `EXMEM_Write`=1.
- FSM has two states, RUN and HOLD:
  - RUN: any hazard produces a stall this cycle. L2 transitions to HOLD; all other hazards stay in RUN.
  - HOLD: stall unconditionally and return to RUN. Hazard inputs are ignored in HOLD. The load has reached MEM, and the following cycle's ID forwarding covers it.
- Flush: in RUN with no hazard, `IFID_Flush`=1 when `ID_PCSrc` is 01 or 10, or when `ID_Branch` AND `ID_BranchTaken`. A stall always suppresses the flush; the branch re-evaluates after the stall.
- `Mem_Busy` freeze:
  - All write enables are 0 and both flushes are 0.
  - FSM state and counters hold.
  - It overrides hazard, HOLD and flush.
- Priority: `reset` > `Mem_Busy` > HOLD > hazard > flush.
- Counters:
  - `Stall_Count` increments on each stall cycle.
  - `Flush_Count` increments on each `IFID_Flush` cycle.
  - Both saturate at all-ones and never wrap.

## Timing
- Control outputs are combinational from state and inputs, with zero latency (same-cycle stall).
- FSM state and counters update on the rising edge of `clk`.
- Reset:
  - At the next edge: state = RUN, both counters = 0.
  - While `reset` is high: `PC_Write`=`IFID_Write`=`EXMEM_Write`=1, both flushes 0, counters do not increment.
- Reset asserted in HOLD returns to RUN; the pending second stall is dropped.
- `Mem_Busy` asserted in HOLD: HOLD persists until `Mem_Busy` falls, then gives exactly one stall cycle.
- Simultaneous L1 and A1/M1 give a single stall cycle, counted once.

## Structure
- Shared `pipeline_pkg` holds:
  - `PCSRC_SEQ/J/JR` encodings;
  - FSM state typedef (RUN, HOLD);
  - register-zero constant.
- Sub-module `sat_counter`: parameterised width, enable, synchronous reset, saturating. Instantiated twice.
- Hazard comparators stay inline.

## Test plan
- `lw $8` in EX; ID `add` with Rs=8 → one stall (`PC_Write`=0, `IDEX_Flush`=1), then normal; `Stall_Count`=1.
- `lw $9` in EX; ID `beq` Rt=9 → stall 2 consecutive cycles via HOLD, then `IFID_Flush`=1 when `ID_BranchTaken`=1; `Stall_Count`=2, `Flush_Count`=1.
- `addi $5` in EX; ID `jr $5` (PCSrc=10) → one stall; next cycle, MEM dest=5 and no stall, so `IFID_Flush`=1.
- Any hazard with EX dest = 0 → no stall; `j` in ID → `IFID_Flush`=1 only.
- L2 detected, then `Mem_Busy`=1 for 3 cycles in HOLD → all enables 0 for 3 cycles, then one stall; `Stall_Count`=2. Separately, reset during HOLD → next cycle RUN, counters 0.
- Force 65 540 stall cycles → `Stall_Count` holds at 16'hFFFF.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: next-PC source encodings, hazard FSM states and
// the hard-wired zero register.
package pipeline_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_J   = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: ID/EX/MEM hazard information in, stage write enables
// and bubble controls out.
interface hazard_ctrl_if;

  logic [4:0] ID_Rs;
  logic [4:0] ID_Rt;
  logic       ID_UseRt;
  logic       ID_Branch;
  logic       ID_BranchTaken;
  logic [1:0] ID_PCSrc;
  logic       EX_MemRead;
  logic       EX_RegWrite;
  logic [4:0] EX_WriteReg;
  logic       MEM_MemRead;
  logic [4:0] MEM_WriteReg;
  logic       Mem_Busy;

  logic       PC_Write;
  logic       IFID_Write;
  logic       EXMEM_Write;
  logic       IFID_Flush;
  logic       IDEX_Flush;

  modport master (
    output ID_Rs, ID_Rt, ID_UseRt, ID_Branch, ID_BranchTaken, ID_PCSrc,
    output EX_MemRead, EX_RegWrite, EX_WriteReg, MEM_MemRead, MEM_WriteReg,
    output Mem_Busy,
    input  PC_Write, IFID_Write, EXMEM_Write, IFID_Flush, IDEX_Flush
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UseRt, ID_Branch, ID_BranchTaken, ID_PCSrc,
    input  EX_MemRead, EX_RegWrite, EX_WriteReg, MEM_MemRead, MEM_WriteReg,
    input  Mem_Busy,
    output PC_Write, IFID_Write, EXMEM_Write, IFID_Flush, IDEX_Flush
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter with enable and synchronous reset that sticks at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: detects hazards forwarding
// cannot cover, inserts bubbles, flushes on taken transfers, counts both.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  hazard_ctrl_if.slave     bus,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count
);

  hz_state_t state;

  logic br_a, br_b;
  logic ex_live, mem_live;
  logic ex_hits_br, ex_hits_alu, mem_hits_br;
  logic haz_l2, haz_l1, haz_a1, haz_m1, hazard;
  logic take_xfer;
  logic stall, flush;

  // Operands consumed in ID by the branch comparator or jr target; the
  // reserved PCSrc code never matches JR/J, so it behaves as sequential.
  always_comb begin
    br_a = bus.ID_Branch | (bus.ID_PCSrc == PCSRC_JR);
    br_b = bus.ID_Branch;

    ex_live  = (bus.EX_WriteReg  != REG_ZERO);
    mem_live = (bus.MEM_WriteReg != REG_ZERO);

    ex_hits_br  = ex_live  & ((br_a & (bus.EX_WriteReg  == bus.ID_Rs)) |
                              (br_b & (bus.EX_WriteReg  == bus.ID_Rt)));
    ex_hits_alu = ex_live  & ((bus.EX_WriteReg == bus.ID_Rs) |
                              (bus.ID_UseRt & (bus.EX_WriteReg == bus.ID_Rt)));
    mem_hits_br = mem_live & ((br_a & (bus.MEM_WriteReg == bus.ID_Rs)) |
                              (br_b & (bus.MEM_WriteReg == bus.ID_Rt)));

    haz_l2 = bus.EX_MemRead & ex_hits_br;
    haz_l1 = bus.EX_MemRead & ex_hits_alu & ~haz_l2;
    haz_a1 = bus.EX_RegWrite & ~bus.EX_MemRead & ex_hits_br;
    haz_m1 = bus.MEM_MemRead & mem_hits_br;
    hazard = haz_l2 | haz_l1 | haz_a1 | haz_m1;

    take_xfer = (bus.ID_PCSrc == PCSRC_J) | (bus.ID_PCSrc == PCSRC_JR) |
                (bus.ID_Branch & bus.ID_BranchTaken);
  end

  always_comb begin
    stall = 1'b0;
    flush = 1'b0;
    if (!reset && !bus.Mem_Busy) begin
      stall = (state == HOLD) | hazard;
      flush = (state == RUN) & ~hazard & take_xfer;
    end
  end

  // Same-cycle control; memory busy freezes every stage register.
  always_comb begin
    bus.PC_Write    = 1'b1;
    bus.IFID_Write  = 1'b1;
    bus.EXMEM_Write = 1'b1;
    bus.IFID_Flush  = 1'b0;
    bus.IDEX_Flush  = 1'b0;
    if (!reset && bus.Mem_Busy) begin
      bus.PC_Write    = 1'b0;
      bus.IFID_Write  = 1'b0;
      bus.EXMEM_Write = 1'b0;
    end else if (stall) begin
      bus.PC_Write    = 1'b0;
      bus.IFID_Write  = 1'b0;
      bus.IDEX_Flush  = 1'b1;
    end else if (flush) begin
      bus.IFID_Flush  = 1'b1;
    end
  end

  // HOLD supplies the second load-to-branch stall, after which ID forwarding
  // from MEM covers the operand.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else if (!bus.Mem_Busy) begin
      case (state)
        RUN:     state <= haz_l2 ? HOLD : RUN;
        HOLD:    state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (stall),
    .count (Stall_Count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (flush),
    .count (Flush_Count)
  );

endmodule
